// File: rtl/cdb_arbiter.sv
// Merges RS and LSB result streams into one registered CDB write per cycle; one-edge FIFO latency (earliest after push edge + 1).
// No CDB backpressure: sources see x_ready low when their FIFO is full, rdy is low, or flush is active.
module cdb_arbiter #(
  parameter int ID_W   = 4,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rdy,
  input  logic              flush,
  input  logic              rss_valid,
  input  logic [ID_W-1:0]   rss_dest,
  input  logic [DATA_W-1:0] rss_value,
  input  logic [DATA_W-1:0] rss_next_pc,
  output logic              rss_ready,
  input  logic              lsb_valid,
  input  logic [ID_W-1:0]   lsb_dest,
  input  logic [DATA_W-1:0] lsb_value,
  output logic              lsb_ready,
  output logic [ID_W-1:0]   cdb_dest,
  output logic [DATA_W-1:0] cdb_value,
  output logic [DATA_W-1:0] cdb_next_pc,
  output logic              cdb_src
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic {SRC_RS = 1'b0, SRC_LSB = 1'b1} src_e;

  logic [ID_W-1:0]   rs_dest_q  [DEPTH];
  logic [DATA_W-1:0] rs_value_q [DEPTH];
  logic [DATA_W-1:0] rs_pc_q    [DEPTH];
  logic [ID_W-1:0]   lsb_dest_q  [DEPTH];
  logic [DATA_W-1:0] lsb_value_q [DEPTH];
  logic [PW-1:0]     rs_wp_q, rs_rp_q, lsb_wp_q, lsb_rp_q;
  logic [CW-1:0]     rs_cnt_q, lsb_cnt_q, rs_cnt_d, lsb_cnt_d;
  src_e              last_grant_q;
  logic [ID_W-1:0]   cdb_dest_q;
  logic [DATA_W-1:0] cdb_value_q, cdb_next_pc_q;
  logic              cdb_src_q;

  logic rs_push, lsb_push, rs_pop, lsb_pop;
  logic rs_ne, lsb_ne, tie, grant_vld, grant_lsb;

  // Ready looks only at occupancy, so a full FIFO never accepts even while popping.
  assign rss_ready = rst_n && rdy && !flush && (rs_cnt_q < FULL);
  assign lsb_ready = rst_n && rdy && !flush && (lsb_cnt_q < FULL);

  always_comb begin
    rs_push   = rss_valid && rss_ready && (rss_dest != '0);
    lsb_push  = lsb_valid && lsb_ready && (lsb_dest != '0);
    rs_ne     = (rs_cnt_q != '0);
    lsb_ne    = (lsb_cnt_q != '0);
    tie       = rs_ne && lsb_ne;
    grant_vld = rdy && !flush && (rs_ne || lsb_ne);
    grant_lsb = tie ? (last_grant_q == SRC_RS) : lsb_ne;
    rs_pop    = grant_vld && !grant_lsb;
    lsb_pop   = grant_vld && grant_lsb;
    rs_cnt_d  = rs_cnt_q + CW'(rs_push) - CW'(rs_pop);
    lsb_cnt_d = lsb_cnt_q + CW'(lsb_push) - CW'(lsb_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        rs_dest_q[i]   <= '0;
        rs_value_q[i]  <= '0;
        rs_pc_q[i]     <= '0;
        lsb_dest_q[i]  <= '0;
        lsb_value_q[i] <= '0;
      end
      rs_wp_q       <= '0;
      rs_rp_q       <= '0;
      lsb_wp_q      <= '0;
      lsb_rp_q      <= '0;
      rs_cnt_q      <= '0;
      lsb_cnt_q     <= '0;
      last_grant_q  <= SRC_LSB;
      cdb_dest_q    <= '0;
      cdb_value_q   <= '0;
      cdb_next_pc_q <= '0;
      cdb_src_q     <= 1'b0;
    end else if (flush) begin
      rs_wp_q      <= '0;
      rs_rp_q      <= '0;
      lsb_wp_q     <= '0;
      lsb_rp_q     <= '0;
      rs_cnt_q     <= '0;
      lsb_cnt_q    <= '0;
      last_grant_q <= SRC_LSB;
      cdb_dest_q   <= '0;
    end else if (rdy) begin
      if (rs_push) begin
        rs_dest_q[rs_wp_q]  <= rss_dest;
        rs_value_q[rs_wp_q] <= rss_value;
        rs_pc_q[rs_wp_q]    <= rss_next_pc;
        rs_wp_q             <= rs_wp_q + PW'(1);
      end
      if (lsb_push) begin
        lsb_dest_q[lsb_wp_q]  <= lsb_dest;
        lsb_value_q[lsb_wp_q] <= lsb_value;
        lsb_wp_q              <= lsb_wp_q + PW'(1);
      end
      if (rs_pop)  rs_rp_q  <= rs_rp_q + PW'(1);
      if (lsb_pop) lsb_rp_q <= lsb_rp_q + PW'(1);
      rs_cnt_q  <= rs_cnt_d;
      lsb_cnt_q <= lsb_cnt_d;
      if (grant_vld) begin
        cdb_dest_q    <= grant_lsb ? lsb_dest_q[lsb_rp_q] : rs_dest_q[rs_rp_q];
        cdb_value_q   <= grant_lsb ? lsb_value_q[lsb_rp_q] : rs_value_q[rs_rp_q];
        cdb_next_pc_q <= grant_lsb ? '0 : rs_pc_q[rs_rp_q];
        cdb_src_q     <= grant_lsb;
        // Round-robin pointer only moves when both sources competed.
        if (tie) last_grant_q <= grant_lsb ? SRC_LSB : SRC_RS;
      end else begin
        cdb_dest_q <= '0;
      end
    end
  end

  assign cdb_dest    = cdb_dest_q;
  assign cdb_value   = cdb_value_q;
  assign cdb_next_pc = cdb_next_pc_q;
  assign cdb_src     = cdb_src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: directed pushes queue expected CDB writes, a negedge monitor checks them.
module tb_cdb_arbiter;

  logic        clk, rst_n, rdy, flush;
  logic        rss_valid, rss_ready, lsb_valid, lsb_ready;
  logic [3:0]  rss_dest, lsb_dest, cdb_dest;
  logic [31:0] rss_value, rss_next_pc, lsb_value, cdb_value, cdb_next_pc;
  logic        cdb_src;

  cdb_arbiter #(.ID_W(4), .DATA_W(32), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .flush(flush),
    .rss_valid(rss_valid), .rss_dest(rss_dest), .rss_value(rss_value),
    .rss_next_pc(rss_next_pc), .rss_ready(rss_ready),
    .lsb_valid(lsb_valid), .lsb_dest(lsb_dest), .lsb_value(lsb_value),
    .lsb_ready(lsb_ready),
    .cdb_dest(cdb_dest), .cdb_value(cdb_value), .cdb_next_pc(cdb_next_pc),
    .cdb_src(cdb_src)
  );

  typedef struct packed {
    logic [3:0]  dest;
    logic [31:0] value;
    logic [31:0] pc;
    logic        src;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  logic fired = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rv(int d); return 32'h100 + d; endfunction
  function automatic logic [31:0] rp(int d); return 32'h200 + d; endfunction
  function automatic logic [31:0] lv(int d); return 32'h300 + d; endfunction

  // An output is new only if the preceding edge was an enabled, non-flush, out-of-reset edge.
  always @(posedge clk) fired <= rst_n && rdy && !flush;

  always @(negedge clk) begin
    if (rst_n && fired && cdb_dest != 4'd0) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL cdb_unexpected: got dest=%0d val=%h src=%0d, nothing expected",
                 cdb_dest, cdb_value, cdb_src);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (cdb_dest !== e.dest || cdb_value !== e.value || cdb_next_pc !== e.pc || cdb_src !== e.src) begin
          n_bad++;
          $display("FAIL cdb_out: got dest=%0d val=%h pc=%h src=%0d, expected dest=%0d val=%h pc=%h src=%0d",
                   cdb_dest, cdb_value, cdb_next_pc, cdb_src, e.dest, e.value, e.pc, e.src);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic rs_in(input int d);
    rss_valid = 1'b1; rss_dest = 4'(d); rss_value = rv(d); rss_next_pc = rp(d);
  endtask

  task automatic lsb_in(input int d);
    lsb_valid = 1'b1; lsb_dest = 4'(d); lsb_value = lv(d);
  endtask

  task automatic idle();
    rss_valid = 1'b0; lsb_valid = 1'b0;
  endtask

  task automatic exp_rs(input int d);
    sb.push_back('{dest: 4'(d), value: rv(d), pc: rp(d), src: 1'b0});
  endtask

  task automatic exp_lsb(input int d);
    sb.push_back('{dest: 4'(d), value: lv(d), pc: 32'h0, src: 1'b1});
  endtask

  task automatic do_reset();
    rst_n = 1'b0; rdy = 1'b1; flush = 1'b0; idle();
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got hang, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rss_dest = '0; rss_value = '0; rss_next_pc = '0; lsb_dest = '0; lsb_value = '0;
    rst_n = 1'b0; rdy = 1'b1; flush = 1'b0; idle();
    repeat (2) tick();
    chk("rst_cdb_dest", cdb_dest, 0);
    chk("rst_cdb_value", cdb_value, 0);
    chk("rst_cdb_next_pc", cdb_next_pc, 0);
    chk("rst_rss_ready", rss_ready, 0);
    chk("rst_lsb_ready", lsb_ready, 0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_rss_ready", rss_ready, 1);

    // 1: single RS result, one-edge latency then idle
    rss_valid = 1'b1; rss_dest = 4'd3; rss_value = 32'h11; rss_next_pc = 32'h104;
    sb.push_back('{dest: 4'd3, value: 32'h11, pc: 32'h104, src: 1'b0});
    tick();
    idle();
    chk("t1_not_bypassed", cdb_dest, 0);
    tick();
    chk("t1_dest", cdb_dest, 3);
    tick();
    chk("t1_one_cycle", cdb_dest, 0);

    // 2: simultaneous pushes after reset, RS wins first tie
    do_reset();
    rs_in(2); lsb_in(5); exp_rs(2); exp_lsb(5);
    tick();
    rs_in(3); lsb_in(6); exp_rs(3); exp_lsb(6);
    tick();
    idle();
    repeat (4) tick();

    // 3: sustained dual load, ids 1..7 per source
    do_reset();
    for (int k = 1; k <= 7; k++) begin
      exp_rs(k); exp_lsb(k);
    end
    begin
      int  ri = 1;
      int  li = 1;
      logic ra, la;
      for (int c = 0; c < 40 && (ri <= 7 || li <= 7); c++) begin
        if (ri <= 7) rs_in(ri); else rss_valid = 1'b0;
        if (li <= 7) lsb_in(li); else lsb_valid = 1'b0;
        #1;
        if (c == 2) begin
          chk("t3_rs_ready_c2", rss_ready, 1);
          chk("t3_lsb_full_c2", lsb_ready, 0);
        end
        if (c == 3) begin
          chk("t3_rs_full_c3", rss_ready, 0);
          chk("t3_lsb_ready_c3", lsb_ready, 1);
        end
        ra = rss_ready && rss_valid;
        la = lsb_ready && lsb_valid;
        tick();
        if (ra) ri++;
        if (la) li++;
      end
      chk("t3_all_rs_accepted", ri, 8);
      chk("t3_all_lsb_accepted", li, 8);
    end
    idle();
    repeat (5) tick();

    // 4: flush with pending entries in both FIFOs
    do_reset();
    rs_in(10); lsb_in(12); exp_rs(10);
    tick();
    rs_in(11); lsb_in(13);
    tick();
    flush = 1'b1; rs_in(14); lsb_in(15);
    #1;
    chk("t4_ready_during_flush", rss_ready, 0);
    tick();
    flush = 1'b0; idle();
    #1;
    chk("t4_flush_dest", cdb_dest, 0);
    chk("t4_rs_ready", rss_ready, 1);
    chk("t4_lsb_ready", lsb_ready, 1);
    rs_in(1); lsb_in(2); exp_rs(1); exp_lsb(2);
    tick();
    idle();
    repeat (4) tick();

    // 5: rdy low holds everything
    rs_in(4); exp_rs(4);
    tick();
    idle(); rdy = 1'b0;
    #1;
    chk("t5_rs_ready_low", rss_ready, 0);
    chk("t5_lsb_ready_low", lsb_ready, 0);
    repeat (3) tick();
    chk("t5_hold_idle", cdb_dest, 0);
    rdy = 1'b1;
    tick();
    chk("t5_after_rdy", cdb_dest, 4);
    rdy = 1'b0;
    repeat (2) tick();
    chk("t5_hold_dest", cdb_dest, 4);
    rdy = 1'b1;
    tick();
    chk("t5_release", cdb_dest, 0);

    // 6: async reset between edges while a result is on the bus
    rs_in(7); exp_rs(7);
    tick();
    idle(); lsb_in(9);
    tick();
    idle();
    chk("t6_dest_before", cdb_dest, 7);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6_async_dest", cdb_dest, 0);
    chk("t6_async_value", cdb_value, 0);
    chk("t6_async_rs_ready", rss_ready, 0);
    chk("t6_async_lsb_ready", lsb_ready, 0);
    #1;
    rst_n = 1'b1;
    repeat (3) tick();
    chk("t6_fifo_empty", cdb_dest, 0);
    chk("t6_rs_ready", rss_ready, 1);

    for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
    chk("sb_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
